// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result returns on one tagged response channel.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Handshakes: a request transfers on a rising edge where reqN_valid && reqN_ready;
   // a response transfers where rsp_valid && rsp_ready. Valid never waits on ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_zero_q, rsp_zero_d;

   logic             grant_any;
   logic             grant_id;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
   assign req1_ready = (state_q == IDLE) && req1_valid && grant_id;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               alu_a_d      = grant_id ? req1_a    : req0_a;
               alu_b_d      = grant_id ? req1_b    : req0_b;
               alu_ctrl_d   = grant_id ? req1_ctrl : req0_ctrl;
               rsp_id_d     = grant_id;
               last_grant_d = grant_id;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_out;
            rsp_zero_d  = alu_zero;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural stand-in for the shared ALU.
module tb_alu_share_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]   req0_ctrl = '0, req1_ctrl = '0;
   logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
   logic [3:0]   alu_ctrl;
   logic         alu_zero, rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, busy;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   ctrl;
      logic [W-1:0] exp_data;
      logic         exp_zero;
   } vec_t;

   vec_t         vecs[9];
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .busy(busy), .dbg_state(dbg_state)
   );

   // Shared ALU model: codes above 8 produce zero.
   always_comb begin
      case (alu_ctrl)
         4'd0:    alu_out = alu_a + alu_b;
         4'd1:    alu_out = alu_a - alu_b;
         4'd2:    alu_out = alu_a & alu_b;
         4'd3:    alu_out = alu_a | alu_b;
         4'd4:    alu_out = alu_a ^ alu_b;
         4'd5:    alu_out = alu_a << alu_b[4:0];
         4'd6:    alu_out = alu_a >> alu_b[4:0];
         4'd7:    alu_out = $signed(alu_a) >>> alu_b[4:0];
         4'd8:    alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         default: alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] c);
      if (id) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_rsp(input string tag, input logic id, input logic [W-1:0] data, input logic zero);
      chk({tag, "_rsp_valid"}, W'(rsp_valid), W'(1));
      chk({tag, "_rsp_id"},    W'(rsp_id),    W'(id));
      chk({tag, "_rsp_data"},  rsp_data,      data);
      chk({tag, "_rsp_zero"},  W'(rsp_zero),  W'(zero));
   endtask

   // One isolated operation from an idle arbiter through response acceptance.
   task automatic run_vec(input vec_t v);
      set_req(v.id, 1'b1, v.a, v.b, v.ctrl);
      #1;
      chk("vec_ready_own",   W'(v.id ? req1_ready : req0_ready), W'(1));
      chk("vec_ready_other", W'(v.id ? req0_ready : req1_ready), W'(0));
      step();
      set_req(v.id, 1'b0, '0, '0, '0);
      #1;
      chk("vec_exec_alu_a",    alu_a,          v.a);
      chk("vec_exec_alu_b",    alu_b,          v.b);
      chk("vec_exec_alu_ctrl", W'(alu_ctrl),   W'(v.ctrl));
      chk("vec_exec_busy",     W'(busy),       W'(1));
      chk("vec_exec_no_rsp",   W'(rsp_valid),  W'(0));
      step();
      check_rsp("vec", v.id, v.exp_data, v.exp_zero);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      chk("vec_after_accept_valid", W'(rsp_valid), W'(0));
      chk("vec_after_accept_busy",  W'(busy),      W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 32'd5,          32'd7,          4'd0,  32'd12,         1'b0};
      vecs[1] = '{1'b1, 32'd9,          32'd9,          4'hF,  32'd0,          1'b1};
      vecs[2] = '{1'b0, 32'd10,         32'd3,          4'd1,  32'd7,          1'b0};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          4'd0,  32'd0,          1'b1};
      vecs[4] = '{1'b0, 32'h0000_F0F0,  32'h0000_FF00,  4'd2,  32'h0000_F000,  1'b0};
      vecs[5] = '{1'b1, 32'd1,          32'd4,          4'd5,  32'h10,         1'b0};
      vecs[6] = '{1'b0, 32'h8000_0000,  32'd4,          4'd7,  32'hF800_0000,  1'b0};
      vecs[7] = '{1'b1, 32'd3,          32'd5,          4'd8,  32'd1,          1'b0};
      vecs[8] = '{1'b0, 32'd7,          32'd7,          4'd9,  32'd0,          1'b1};

      do_reset();
      #1;
      chk("rst_alu_a",     alu_a,          '0);
      chk("rst_alu_b",     alu_b,          '0);
      chk("rst_alu_ctrl",  W'(alu_ctrl),   '0);
      chk("rst_rsp_valid", W'(rsp_valid),  '0);
      chk("rst_rsp_id",    W'(rsp_id),     '0);
      chk("rst_rsp_data",  rsp_data,       '0);
      chk("rst_rsp_zero",  W'(rsp_zero),   '0);
      chk("rst_busy",      W'(busy),       '0);
      chk("rst_readys",    W'({req0_ready, req1_ready}), '0);
      #1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Tie in the first cycle after reset: requester 0 first, requester 1 right after acceptance.
      do_reset();
      set_req(1'b0, 1'b1, 32'd3, 32'd3, 4'd1);
      set_req(1'b1, 1'b1, 32'hF0, 32'h0F, 4'd3);
      #1;
      chk("tie_req0_ready", W'(req0_ready), W'(1));
      chk("tie_req1_ready", W'(req1_ready), W'(0));
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("tie_exec_readys", W'({req0_ready, req1_ready}), '0);
      step();
      check_rsp("tie0", 1'b0, 32'd0, 1'b1);
      chk("tie_resp_req1_ready", W'(req1_ready), W'(0));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      chk("tie_req1_granted_next", W'(req1_ready), W'(1));
      step();
      set_req(1'b1, 1'b0, '0, '0, '0);
      step();
      check_rsp("tie1", 1'b1, 32'hFF, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Both held valid for four operations: strict alternation.
      exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
      set_req(1'b0, 1'b1, 32'd3, 32'd3, 4'd1);
      set_req(1'b1, 1'b1, 32'hF0, 32'h0F, 4'd3);
      for (int k = 0; k < 4; k++) begin
         int waited;
         logic [W-1:0] exp_id;
         waited = 0;
         while (!rsp_valid && waited < 6) begin
            step();
            waited++;
         end
         exp_id = exp_q.pop_front();
         chk("alt_rsp_seen",  W'(rsp_valid), W'(1));
         chk("alt_latency",   W'(waited <= 3), W'(1));
         chk("alt_rsp_id",    W'(rsp_id), exp_id);
         chk("alt_rsp_data",  rsp_data, exp_id[0] ? 32'hFF : 32'd0);
         rsp_ready = 1'b1;
         if (k == 3) begin
            set_req(1'b0, 1'b0, '0, '0, '0);
            set_req(1'b1, 1'b0, '0, '0, '0);
         end
         step();
         rsp_ready = 1'b0;
      end

      // Response backpressure for five cycles with requester 0 knocking.
      set_req(1'b1, 1'b1, 32'd1, 32'd4, 4'd5);
      #1;
      chk("bp_req1_ready", W'(req1_ready), W'(1));
      step();
      set_req(1'b1, 1'b0, '0, '0, '0);
      step();
      set_req(1'b0, 1'b1, 32'd2, 32'd2, 4'd0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check_rsp("bp", 1'b1, 32'h10, 1'b0);
         chk("bp_busy",   W'(busy), W'(1));
         chk("bp_readys", W'({req0_ready, req1_ready}), '0);
         step();
      end
      set_req(1'b0, 1'b0, '0, '0, '0);
      rsp_ready = 1'b1;
      #1;
      chk("bp_still_valid", W'(rsp_valid), W'(1));
      step();
      rsp_ready = 1'b0;
      #1;
      chk("bp_accepted", W'(rsp_valid), W'(0));

      // Asynchronous reset while an operation from requester 0 is executing.
      set_req(1'b0, 1'b1, 32'd5, 32'd7, 4'd0);
      #1;
      chk("ar_req0_ready", W'(req0_ready), W'(1));
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("ar_in_exec", W'(busy), W'(1));
      reset = 1'b1;
      #1;
      chk("ar_busy",      W'(busy),      '0);
      chk("ar_rsp_valid", W'(rsp_valid), '0);
      chk("ar_rsp_data",  rsp_data,      '0);
      chk("ar_alu_a",     alu_a,         '0);
      chk("ar_alu_b",     alu_b,         '0);
      chk("ar_alu_ctrl",  W'(alu_ctrl),  '0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("ar_no_rsp", W'(rsp_valid), '0);
         step();
      end
      set_req(1'b0, 1'b1, 32'd5, 32'd7, 4'd0);
      set_req(1'b1, 1'b1, 32'd1, 32'd1, 4'd0);
      #1;
      chk("ar_tie_req0_ready", W'(req0_ready), W'(1));
      chk("ar_tie_req1_ready", W'(req1_ready), W'(0));
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0, '0);
      step();
      check_rsp("ar_after", 1'b0, 32'd12, 1'b0);
      rsp_ready = 1'b1;
      step();

      // rsp_ready while nothing is pending has no effect.
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("idle_ready_valid", W'(rsp_valid), '0);
         chk("idle_ready_busy",  W'(busy),      '0);
         step();
      end
      rsp_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
